mbc_banked: RTL and testbench
=============================

// Module: mbc_banked
// PURPOSE
//  Parametrised cartridge memory bank controller; successor to the fixed 2-bit ROM-bank mapper.
//  Decodes CPU accesses to 0000-7FFF (ROM + bank registers) and A000-BFFF (cart RAM).
//  Translates them into a flat backing-memory address with a req/ack handshake to the SRAM port.
//  Adds a full bank-register set: RAM enable, low/high bank, banking mode, ROM size mask.
// PARAMETERS
//  ROM_LO_BITS    5      width of low ROM bank register (2000-3FFF)
//  HI_BITS        2      width of high bank register (4000-5FFF)
//  ROM_BANK_MASK  all-1s mask applied to final ROM bank; width ROM_LO_BITS+HI_BITS
//  MEM_ADDR_W     14+ROM_LO_BITS+HI_BITS   backing-memory byte address width
// PORTS
//  clockgb    in   1           system clock; all state changes on rising edge
//  reset      in   1           synchronous, active-high reset
//  address    in   16          CPU address
//  indata     in   8           CPU write data
//  outdata    out  8           CPU read data (registered)
//  load       in   1           one-cycle read strobe
//  store      in   1           one-cycle write strobe
//  busy       out  1           high while a memory transaction is outstanding
//  mem_addr   out  MEM_ADDR_W  backing-memory address, held stable while mem_rd/mem_wr high
//  mem_sel    out  1           0 = ROM image, 1 = cart RAM image
//  mem_rd     out  1           read request, held until mem_ack
//  mem_wr     out  1           write request, held until mem_ack
//  mem_wdata  out  8           write data, held with mem_wr
//  mem_rdata  in   8           read data, valid in the mem_ack cycle
//  mem_ack    in   1           one-cycle completion from backing memory
// BEHAVIOUR
//  Reset: ram_en=0, bank_lo=1, bank_hi=0, mode=0, state IDLE, outdata=FF, busy/mem_rd/mem_wr=0.
//  Register writes (store, IDLE, one cycle, busy stays 0, no memory request):
//   0000-1FFF: ram_en <= (indata[3:0]==4'hA).
//   2000-3FFF: bank_lo <= indata[ROM_LO_BITS-1:0]; all-zero value is written as 1.
//   4000-5FFF: bank_hi <= indata[HI_BITS-1:0].   6000-7FFF: mode <= indata[0].
//  Bank mapping (ROM_BANK_MASK applied after concatenation):
//   0000-3FFF: bank = mode ? {bank_hi,0} : 0.   4000-7FFF: bank = {bank_hi,bank_lo}.
//   RAM bank = mode ? bank_hi : 0; mem_addr = {bank, address[13:0]} (RAM: {rbank,address[12:0]}, zero-extended).
//  FSM IDLE -> RD_WAIT | WR_WAIT -> IDLE:
//   IDLE + load to ROM window, or RAM window with ram_en: assert mem_rd, busy; -> RD_WAIT.
//   RD_WAIT + mem_ack: outdata <= mem_rdata, drop mem_rd/busy same edge; -> IDLE. Latency = ack cycle + 1.
//   IDLE + store to RAM window with ram_en: assert mem_wr, mem_wdata=indata; -> WR_WAIT; ack -> IDLE.
//   RAM load with ram_en=0: outdata <= FF next cycle, no request. RAM store with ram_en=0: dropped.
//   load/store outside both windows: ignored, outdata unchanged.
//  Boundaries:
//   load and store same cycle: store wins, load dropped.
//   strobes while busy: dropped (CPU must stall on busy); bank registers not updated.
//   mem_ack in IDLE: ignored.
//   reset in RD_WAIT/WR_WAIT: -> IDLE, requests drop next edge, late ack ignored.
//   bank_lo nonzero but masked to zero by ROM_BANK_MASK: no 0->1 correction after mask.
// CONFIGURATION
//  MBC_RAM_EN defined: A000-BFFF window, ram_en register, WR_WAIT path as above.
//  MBC_RAM_EN undefined: no RAM window; A000-BFFF loads ignored; mem_sel tied 0; mem_wr tied 0;
//   0000-1FFF writes ignored; mode still affects ROM mapping only.
// STRUCTURE
//  Package mbc_pkg: window base/limit constants (ROM0, ROMX, RAMEN, BANKLO, BANKHI, MODE, RAM),
//   FSM state typedef {IDLE, RD_WAIT, WR_WAIT}, RAM_EN_KEY = 4'hA.
//  Sub-module mbc_bank_regs: register file + bank mapping (combinational bank outputs);
//   top holds decode, FSM and handshake.
// TESTING
//  Reset, load 0x4123, ack after 3 cycles with 5A -> mem_addr=0x04123 (bank 1), outdata=5A, busy 4 cycles.
//  store 0x2000=00 then 0x2000=13, store 0x4000=2 -> load 0x7FFF gives mem_addr={7'h53,14'h3FFF}.
//  mode=1, bank_hi=3, ROM_BANK_MASK=0x3F: load 0x0010 -> bank 0x20 masked -> mem_addr=0x80010.
//  ram_en=0: load 0xA000 -> outdata=FF, mem_rd never high; store 0x0000=0A, store 0xA001=77 -> mem_wr, mem_sel=1, wdata=77.
//  load and store same cycle to 0x2000=05: bank_lo=5, no mem_rd; strobe during RD_WAIT dropped.
//  Reset during RD_WAIT, then mem_ack: state IDLE, outdata=FF, no capture.

Source files
------------

// File: rtl/mbc_pkg.sv
// Shared constants and types for the banked cartridge memory controller.
package mbc_pkg;

  localparam logic [15:0] ROM0_BASE    = 16'h0000;
  localparam logic [15:0] ROM0_LIMIT   = 16'h3FFF;
  localparam logic [15:0] ROMX_BASE    = 16'h4000;
  localparam logic [15:0] ROMX_LIMIT   = 16'h7FFF;
  localparam logic [15:0] RAMEN_BASE   = 16'h0000;
  localparam logic [15:0] RAMEN_LIMIT  = 16'h1FFF;
  localparam logic [15:0] BANKLO_BASE  = 16'h2000;
  localparam logic [15:0] BANKLO_LIMIT = 16'h3FFF;
  localparam logic [15:0] BANKHI_BASE  = 16'h4000;
  localparam logic [15:0] BANKHI_LIMIT = 16'h5FFF;
  localparam logic [15:0] MODE_BASE    = 16'h6000;
  localparam logic [15:0] MODE_LIMIT   = 16'h7FFF;
  localparam logic [15:0] RAM_BASE     = 16'hA000;
  localparam logic [15:0] RAM_LIMIT    = 16'hBFFF;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mbc_state_e;

  function automatic logic in_window(input logic [15:0] a,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/mbc_if.sv
// CPU-side and backing-memory-side bus of the banked cartridge controller.
// master = the controller view, slave = the CPU/memory environment view.
interface mbc_if #(
  parameter int MEM_ADDR_W = 21
);
  logic [15:0]           address;
  logic [7:0]            indata;
  logic [7:0]            outdata;
  logic                  load;
  logic                  store;
  logic                  busy;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_sel;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  mem_ack;

  modport master (
    input  address, indata, load, store, mem_rdata, mem_ack,
    output outdata, busy, mem_addr, mem_sel, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output address, indata, load, store, mem_rdata, mem_ack,
    input  outdata, busy, mem_addr, mem_sel, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mbc_bank_regs.sv
// Bank register file and combinational bank mapping.
// RAM enable / RAM bank ports exist only when MBC_RAM_EN is defined.
module mbc_bank_regs
  import mbc_pkg::*;
#(
  parameter int ROM_LO_BITS = 5,
  parameter int HI_BITS     = 2,
  parameter logic [ROM_LO_BITS+HI_BITS-1:0] ROM_BANK_MASK = '1
) (
  input  logic                           clockgb,
  input  logic                           reset,
  input  logic                           we_lo,
  input  logic                           we_hi,
  input  logic                           we_mode,
`ifdef MBC_RAM_EN
  input  logic                           we_ramen,
  output logic                           ram_en,
  output logic [HI_BITS-1:0]             ram_bank,
`endif
  input  logic [ROM_LO_BITS-1:0]         wr_data,
  input  logic                           upper_half,
  output logic [ROM_LO_BITS+HI_BITS-1:0] rom_bank
);

  logic [ROM_LO_BITS-1:0] bank_lo;
  logic [HI_BITS-1:0]     bank_hi;
  logic                   mode;
  logic [ROM_LO_BITS+HI_BITS-1:0] raw_bank;

  always_ff @(posedge clockgb) begin
    if (reset) begin
      bank_lo <= ROM_LO_BITS'(1);
      bank_hi <= '0;
      mode    <= 1'b0;
    end else begin
      // bank 0 is never selectable in the switchable window
      if (we_lo)   bank_lo <= (wr_data == '0) ? ROM_LO_BITS'(1) : wr_data;
      if (we_hi)   bank_hi <= wr_data[HI_BITS-1:0];
      if (we_mode) mode    <= wr_data[0];
    end
  end

`ifdef MBC_RAM_EN
  always_ff @(posedge clockgb) begin
    if (reset)         ram_en <= 1'b0;
    else if (we_ramen) ram_en <= (wr_data[3:0] == RAM_EN_KEY);
  end

  assign ram_bank = mode ? bank_hi : '0;
`endif

  always_comb begin
    raw_bank = '0;
    if (upper_half)  raw_bank = {bank_hi, bank_lo};
    else if (mode)   raw_bank = {bank_hi, {ROM_LO_BITS{1'b0}}};
  end

  // mask is applied after the zero correction, so a masked bank may still be 0
  assign rom_bank = raw_bank & ROM_BANK_MASK;

endmodule

// File: rtl/mbc_banked.sv
// Banked cartridge memory controller: CPU decode, FSM and backing-memory handshake.
// Build option MBC_RAM_EN adds the A000-BFFF cart RAM window and RAM write path.
module mbc_banked
  import mbc_pkg::*;
#(
  parameter int ROM_LO_BITS = 5,
  parameter int HI_BITS     = 2,
  parameter logic [ROM_LO_BITS+HI_BITS-1:0] ROM_BANK_MASK = '1,
  parameter int MEM_ADDR_W  = 14 + ROM_LO_BITS + HI_BITS
) (
  input  logic  clockgb,
  input  logic  reset,
  mbc_if.master bus
);

  localparam int BANK_W = ROM_LO_BITS + HI_BITS;

  mbc_state_e            state_q, state_nxt;
  logic [7:0]            outdata_q, outdata_nxt;
  logic                  busy_q, busy_nxt;
  logic                  rd_q, rd_nxt;
  logic                  wr_q, wr_nxt;
  logic                  sel_q, sel_nxt;
  logic [MEM_ADDR_W-1:0] addr_q, addr_nxt;
  logic [7:0]            wdata_q, wdata_nxt;

  logic [BANK_W-1:0]     rom_bank;
  logic                  rom_win;
  logic                  reg_wr;
  logic                  we_lo, we_hi, we_mode;

  assign rom_win = in_window(bus.address, ROM0_BASE, ROMX_LIMIT);
  assign reg_wr  = (state_q == IDLE) && bus.store && rom_win;
  assign we_lo   = reg_wr && in_window(bus.address, BANKLO_BASE, BANKLO_LIMIT);
  assign we_hi   = reg_wr && in_window(bus.address, BANKHI_BASE, BANKHI_LIMIT);
  assign we_mode = reg_wr && in_window(bus.address, MODE_BASE, MODE_LIMIT);

`ifdef MBC_RAM_EN
  logic                  ram_win;
  logic                  ram_en;
  logic                  we_ramen;
  logic [HI_BITS-1:0]    ram_bank;
  logic [MEM_ADDR_W-1:0] ram_addr;

  assign ram_win  = in_window(bus.address, RAM_BASE, RAM_LIMIT);
  assign we_ramen = reg_wr && in_window(bus.address, RAMEN_BASE, RAMEN_LIMIT);
  assign ram_addr = MEM_ADDR_W'({ram_bank, bus.address[12:0]});
`endif

  mbc_bank_regs #(
    .ROM_LO_BITS   (ROM_LO_BITS),
    .HI_BITS       (HI_BITS),
    .ROM_BANK_MASK (ROM_BANK_MASK)
  ) u_regs (
    .clockgb    (clockgb),
    .reset      (reset),
    .we_lo      (we_lo),
    .we_hi      (we_hi),
    .we_mode    (we_mode),
`ifdef MBC_RAM_EN
    .we_ramen   (we_ramen),
    .ram_en     (ram_en),
    .ram_bank   (ram_bank),
`endif
    .wr_data    (bus.indata[ROM_LO_BITS-1:0]),
    .upper_half (bus.address[14]),
    .rom_bank   (rom_bank)
  );

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state_q   <= IDLE;
      outdata_q <= 8'hFF;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_nxt;
      outdata_q <= outdata_nxt;
      busy_q    <= busy_nxt;
      rd_q      <= rd_nxt;
      wr_q      <= wr_nxt;
      sel_q     <= sel_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    outdata_nxt = outdata_q;
    busy_nxt    = busy_q;
    rd_nxt      = rd_q;
    wr_nxt      = wr_q;
    sel_nxt     = sel_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    case (state_q)
      IDLE: begin
        // store has priority; a simultaneous load is dropped
        if (bus.store) begin
          wdata_nxt = bus.indata;
`ifdef MBC_RAM_EN
          if (ram_win && ram_en) begin
            wr_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            sel_nxt   = 1'b1;
            addr_nxt  = ram_addr;
            state_nxt = WR_WAIT;
          end
`endif
        end else if (bus.load) begin
          if (rom_win) begin
            rd_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            sel_nxt   = 1'b0;
            addr_nxt  = MEM_ADDR_W'({rom_bank, bus.address[13:0]});
            state_nxt = RD_WAIT;
          end
`ifdef MBC_RAM_EN
          else if (ram_win) begin
            if (ram_en) begin
              rd_nxt    = 1'b1;
              busy_nxt  = 1'b1;
              sel_nxt   = 1'b1;
              addr_nxt  = ram_addr;
              state_nxt = RD_WAIT;
            end else begin
              outdata_nxt = 8'hFF;
            end
          end
`endif
        end
      end
      RD_WAIT: begin
        if (bus.mem_ack) begin
          outdata_nxt = bus.mem_rdata;
          rd_nxt      = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end
      WR_WAIT: begin
        if (bus.mem_ack) begin
          wr_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.outdata   = outdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mbc_banked.sv
// Directed bench for mbc_banked: default-mask DUT plus a ROM_BANK_MASK=0x3F DUT
// driven with identical stimulus. Covers RAM window behaviour for either MBC_RAM_EN build.
module tb_mbc_banked;

  logic        clockgb = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic        load, store;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;
  int vec_idx  = 0;

  always #5 clockgb = ~clockgb;

  mbc_if #(.MEM_ADDR_W(21)) bus_a ();
  mbc_if #(.MEM_ADDR_W(21)) bus_b ();

  assign bus_a.address   = address;
  assign bus_a.indata    = indata;
  assign bus_a.load      = load;
  assign bus_a.store     = store;
  assign bus_a.mem_rdata = mem_rdata;
  assign bus_a.mem_ack   = mem_ack;
  assign bus_b.address   = address;
  assign bus_b.indata    = indata;
  assign bus_b.load      = load;
  assign bus_b.store     = store;
  assign bus_b.mem_rdata = mem_rdata;
  assign bus_b.mem_ack   = mem_ack;

  mbc_banked dut_a (
    .clockgb (clockgb),
    .reset   (reset),
    .bus     (bus_a)
  );

  mbc_banked #(.ROM_BANK_MASK(7'h3F)) dut_b (
    .clockgb (clockgb),
    .reset   (reset),
    .bus     (bus_b)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  req;    // 0 none, 1 read, 2 write
    int          waits;
    logic [7:0]  rdata;
    logic [20:0] ea;
    logic [20:0] eb;
    logic        esel;
    logic [7:0]  eout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic ld, input logic st, input logic [15:0] addr,
                             input logic [7:0] data, input logic [1:0] req, input int waits,
                             input logic [7:0] rdata, input logic [20:0] ea,
                             input logic [20:0] eb, input logic esel, input logic [7:0] eout);
    vec_t r;
    r.ld = ld; r.st = st; r.addr = addr; r.data = data; r.req = req; r.waits = waits;
    r.rdata = rdata; r.ea = ea; r.eb = eb; r.esel = esel; r.eout = eout;
    return r;
  endfunction

  task automatic tick();
    @(posedge clockgb);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (vec %0d) actual=%0h required=%0h", name, vec_idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    address = t.addr; indata = t.data; load = t.ld; store = t.st;
    tick();
    load = 1'b0; store = 1'b0; address = 16'hFFFF; indata = 8'h00;
    if (t.req == 2'd0) begin
      chk("idle_busy", 32'(bus_a.busy), 32'd0);
      chk("idle_rd",   32'(bus_a.mem_rd), 32'd0);
      chk("idle_wr",   32'(bus_a.mem_wr), 32'd0);
    end else begin
      chk("req_rd",   32'(bus_a.mem_rd), 32'(t.req == 2'd1));
      chk("req_wr",   32'(bus_a.mem_wr), 32'(t.req == 2'd2));
      chk("req_busy", 32'(bus_a.busy), 32'd1);
      chk("addr_a",   32'(bus_a.mem_addr), 32'(t.ea));
      chk("addr_b",   32'(bus_b.mem_addr), 32'(t.eb));
      chk("sel",      32'(bus_a.mem_sel), 32'(t.esel));
      if (t.req == 2'd2) chk("wdata", 32'(bus_a.mem_wdata), 32'(t.data));
      repeat (t.waits) tick();
      chk("hold_addr", 32'(bus_a.mem_addr), 32'(t.ea));
      chk("hold_req",  32'(bus_a.mem_rd | bus_a.mem_wr), 32'd1);
      mem_ack = 1'b1; mem_rdata = t.rdata;
      tick();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("done_busy", 32'(bus_a.busy), 32'd0);
      chk("done_req",  32'(bus_a.mem_rd | bus_a.mem_wr), 32'd0);
    end
    chk("outdata", 32'(bus_a.outdata), 32'(t.eout));
    vec_idx++;
  endtask

`ifdef MBC_RAM_EN
  localparam logic [7:0] LAST_OUT = 8'h42;
`else
  localparam logic [7:0] LAST_OUT = 8'h77;
`endif

  initial begin
    int busy_cycles;
    reset = 1'b1; address = 16'h0000; indata = 8'h00; load = 1'b0; store = 1'b0;
    mem_rdata = 8'h00; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_outdata", 32'(bus_a.outdata), 32'hFF);
    chk("rst_busy",    32'(bus_a.busy), 32'd0);
    chk("rst_rd",      32'(bus_a.mem_rd), 32'd0);
    chk("rst_wr",      32'(bus_a.mem_wr), 32'd0);
    chk("rst_sel",     32'(bus_a.mem_sel), 32'd0);

    // first read: ack three cycles after the request, busy spans four cycles
    busy_cycles = 0;
    address = 16'h4123; load = 1'b1;
    tick();
    load = 1'b0; address = 16'h0000;
    chk("first_addr", 32'(bus_a.mem_addr), 32'h04123);
    for (int i = 0; i < 3; i++) begin
      if (bus_a.busy) busy_cycles++;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    if (bus_a.busy) busy_cycles++;
    tick();
    mem_ack = 1'b0;
    if (bus_a.busy) busy_cycles++;
    chk("first_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("first_outdata",     32'(bus_a.outdata), 32'h5A);
    vec_idx++;

    tbl.push_back(v(0, 1, 16'h2000, 8'h00, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h5A));
    tbl.push_back(v(1, 0, 16'h4000, 8'h00, 1, 1, 8'h11, 21'h04000,  21'h04000, 0, 8'h11));
    tbl.push_back(v(0, 1, 16'h2000, 8'h13, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h11));
    tbl.push_back(v(0, 1, 16'h4000, 8'h02, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h11));
    tbl.push_back(v(1, 0, 16'h7FFF, 8'h00, 1, 2, 8'h22, 21'h14FFFF, 21'h4FFFF, 0, 8'h22));
    tbl.push_back(v(1, 0, 16'h0010, 8'h00, 1, 0, 8'h33, 21'h00010,  21'h00010, 0, 8'h33));
    tbl.push_back(v(0, 1, 16'h6000, 8'h01, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h33));
    tbl.push_back(v(1, 0, 16'h0010, 8'h00, 1, 1, 8'h44, 21'h100010, 21'h00010, 0, 8'h44));
    tbl.push_back(v(0, 1, 16'h4000, 8'h03, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h44));
    tbl.push_back(v(1, 0, 16'h0010, 8'h00, 1, 3, 8'h55, 21'h180010, 21'h80010, 0, 8'h55));
    tbl.push_back(v(1, 0, 16'h8000, 8'h00, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h55));
    tbl.push_back(v(0, 1, 16'h9000, 8'h12, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h55));
    tbl.push_back(v(1, 0, 16'h5000, 8'h00, 1, 1, 8'h66, 21'h1CD000, 21'hCD000, 0, 8'h66));
    tbl.push_back(v(0, 1, 16'h6000, 8'h00, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h66));
    tbl.push_back(v(1, 0, 16'h2000, 8'h00, 1, 0, 8'h77, 21'h02000,  21'h02000, 0, 8'h77));
`ifdef MBC_RAM_EN
    tbl.push_back(v(1, 0, 16'hA000, 8'h00, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'hFF));
    tbl.push_back(v(0, 1, 16'h0000, 8'h0A, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'hFF));
    tbl.push_back(v(0, 1, 16'hA001, 8'h77, 2, 2, 8'h00, 21'h00001,  21'h00001, 1, 8'hFF));
    tbl.push_back(v(1, 0, 16'hA123, 8'h00, 1, 1, 8'h42, 21'h00123,  21'h00123, 1, 8'h42));
`else
    tbl.push_back(v(1, 0, 16'hA000, 8'h00, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h77));
    tbl.push_back(v(0, 1, 16'h0000, 8'h0A, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h77));
    tbl.push_back(v(0, 1, 16'hA001, 8'h77, 0, 0, 8'h00, 21'h0,      21'h0,     0, 8'h77));
`endif
    foreach (tbl[i]) run_vec(tbl[i]);

    // load and store together: store wins, bank_lo becomes 5
    run_vec(v(1, 1, 16'h2000, 8'h05, 0, 0, 8'h00, 21'h0, 21'h0, 0, LAST_OUT));

    // strobes while RD_WAIT are dropped and do not touch the bank registers
    address = 16'h4000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("busy_req_addr", 32'(bus_a.mem_addr), 32'h194000);
    address = 16'h2000; indata = 8'h09; store = 1'b1;
    tick();
    store = 1'b0; address = 16'h7000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("busy_addr_hold", 32'(bus_a.mem_addr), 32'h194000);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("busy_outdata", 32'(bus_a.outdata), 32'h3C);
    tick();
    chk("busy_no_new_rd", 32'(bus_a.mem_rd), 32'd0);
    vec_idx++;
    run_vec(v(1, 0, 16'h4000, 8'h00, 1, 0, 8'h5D, 21'h194000, 21'h94000, 0, 8'h5D));

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_out",  32'(bus_a.outdata), 32'h5D);
    chk("idle_ack_busy", 32'(bus_a.busy), 32'd0);
    vec_idx++;

    // reset in RD_WAIT, then a late ack
    address = 16'h4000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("rstrd_req", 32'(bus_a.mem_rd), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrd_rd",   32'(bus_a.mem_rd), 32'd0);
    chk("rstrd_busy", 32'(bus_a.busy), 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    chk("rstrd_out",     32'(bus_a.outdata), 32'hFF);
    chk("rstrd_busy2",   32'(bus_a.busy), 32'd0);
    chk("rstrd_rd2",     32'(bus_a.mem_rd), 32'd0);
    vec_idx++;
    run_vec(v(1, 0, 16'h4000, 8'h00, 1, 1, 8'hA5, 21'h04000, 21'h04000, 0, 8'hA5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
